axi_4_lite_arbiter: RTL and testbench

Two-master, one-slave AXI4-lite arbiter. It shares a single memory slave between M0 (instruction fetch) and M1 (load/store). Exactly one transaction is in flight at a time, and masters are served round-robin at transaction granularity. It sits between the IFU/LSU AXI master ports and the memory model.

---
 rtl/axi_4_lite_pkg.sv | 21 ++
 rtl/axi_4_lite_arbiter_if.sv | 42 ++++
 rtl/axi_arb_rr2.sv | 18 +
 rtl/axi_4_lite_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_axi_4_lite_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_4_lite_pkg.sv
// Shared definitions for the two-master AXI4-lite arbiter: FSM state encodings,
// response codes and master identifiers.
package axi_4_lite_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic MST_M0 = 1'b0;
  localparam logic MST_M1 = 1'b1;

endpackage

// File: rtl/axi_4_lite_arbiter_if.sv
// One AXI4-lite port bundle; 'master' is the side issuing requests, 'slave' the
// side answering them.
interface axi_4_lite_arbiter_if #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32
);
  logic [AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]                  awprot;
  logic                        awvalid;
  logic                        awready;
  logic [AXI_DATA_WIDTH-1:0]   wdata;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                        wvalid;
  logic                        wready;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  logic [AXI_ADDR_WIDTH-1:0]   araddr;
  logic [2:0]                  arprot;
  logic                        arvalid;
  logic                        arready;
  logic [AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rvalid;
  logic                        rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_arb_rr2.sv
// Two-requester round-robin pick: a lone requester always wins, on conflict the
// requester named by prio wins. Output is one-hot (or zero when idle).
module axi_arb_rr2
  import axi_4_lite_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (prio == MST_M1) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/axi_4_lite_arbiter.sv
// Shares one AXI4-lite slave between two masters, one transaction at a time,
// round-robin at transaction granularity. Channels are routed combinationally.
module axi_4_lite_arbiter
  import axi_4_lite_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic AXI_ACLK,
  input  logic AXI_ARESET,
  axi_4_lite_arbiter_if.slave  m0,
  axi_4_lite_arbiter_if.slave  m1,
  axi_4_lite_arbiter_if.master s
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;

  state_e state_q, state_d;
  logic   prio_q, prio_d;
  logic   gnt_q, gnt_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;

  logic [1:0] req;
  logic [1:0] arb_gnt;

  assign req = {m1.awvalid | m1.wvalid | m1.arvalid,
                m0.awvalid | m0.wvalid | m0.arvalid};

  axi_arb_rr2 u_arb (
    .req  (req),
    .prio (prio_q),
    .gnt  (arb_gnt)
  );

  // Request-side view of whichever master currently holds the grant
  logic [AXI_ADDR_WIDTH-1:0] g_awaddr, g_araddr;
  logic [2:0]                g_awprot, g_arprot;
  logic [AXI_DATA_WIDTH-1:0] g_wdata;
  logic [STRB_W-1:0]         g_wstrb;
  logic                      g_awvalid, g_wvalid, g_arvalid, g_bready, g_rready;

  assign g_awaddr  = gnt_q ? m1.awaddr  : m0.awaddr;
  assign g_awprot  = gnt_q ? m1.awprot  : m0.awprot;
  assign g_awvalid = gnt_q ? m1.awvalid : m0.awvalid;
  assign g_wdata   = gnt_q ? m1.wdata   : m0.wdata;
  assign g_wstrb   = gnt_q ? m1.wstrb   : m0.wstrb;
  assign g_wvalid  = gnt_q ? m1.wvalid  : m0.wvalid;
  assign g_bready  = gnt_q ? m1.bready  : m0.bready;
  assign g_araddr  = gnt_q ? m1.araddr  : m0.araddr;
  assign g_arprot  = gnt_q ? m1.arprot  : m0.arprot;
  assign g_arvalid = gnt_q ? m1.arvalid : m0.arvalid;
  assign g_rready  = gnt_q ? m1.rready  : m0.rready;

  logic                      rt_awready, rt_wready, rt_bvalid, rt_arready, rt_rvalid;
  logic [1:0]                rt_bresp, rt_rresp;
  logic [AXI_DATA_WIDTH-1:0] rt_rdata;

  always_comb begin
    s.awaddr   = '0;
    s.awprot   = '0;
    s.awvalid  = 1'b0;
    s.wdata    = '0;
    s.wstrb    = '0;
    s.wvalid   = 1'b0;
    s.bready   = 1'b0;
    s.araddr   = '0;
    s.arprot   = '0;
    s.arvalid  = 1'b0;
    s.rready   = 1'b0;
    rt_awready = 1'b0;
    rt_wready  = 1'b0;
    rt_bvalid  = 1'b0;
    rt_bresp   = '0;
    rt_arready = 1'b0;
    rt_rvalid  = 1'b0;
    rt_rresp   = '0;
    rt_rdata   = '0;
    unique case (state_q)
      ST_RD_ADDR: begin
        s.araddr   = g_araddr;
        s.arprot   = g_arprot;
        s.arvalid  = g_arvalid;
        rt_arready = s.arready;
      end
      ST_RD_DATA: begin
        s.rready  = g_rready;
        rt_rvalid = s.rvalid;
        rt_rdata  = s.rdata;
        rt_rresp  = s.rresp;
      end
      ST_WR_REQ: begin
        // A channel that already handshook is muted so the slave sees it once
        s.awaddr   = g_awaddr;
        s.awprot   = g_awprot;
        s.awvalid  = g_awvalid & ~aw_done_q;
        rt_awready = s.awready & ~aw_done_q;
        s.wdata    = g_wdata;
        s.wstrb    = g_wstrb;
        s.wvalid   = g_wvalid & ~w_done_q;
        rt_wready  = s.wready & ~w_done_q;
      end
      ST_WR_RESP: begin
        s.bready  = g_bready;
        rt_bvalid = s.bvalid;
        rt_bresp  = s.bresp;
      end
      default: ;
    endcase
  end

  logic sel0, sel1;
  assign sel0 = (gnt_q == MST_M0);
  assign sel1 = (gnt_q == MST_M1);

  assign m0.awready = sel0 & rt_awready;
  assign m0.wready  = sel0 & rt_wready;
  assign m0.bvalid  = sel0 & rt_bvalid;
  assign m0.bresp   = sel0 ? rt_bresp : '0;
  assign m0.arready = sel0 & rt_arready;
  assign m0.rvalid  = sel0 & rt_rvalid;
  assign m0.rresp   = sel0 ? rt_rresp : '0;
  assign m0.rdata   = sel0 ? rt_rdata : '0;

  assign m1.awready = sel1 & rt_awready;
  assign m1.wready  = sel1 & rt_wready;
  assign m1.bvalid  = sel1 & rt_bvalid;
  assign m1.bresp   = sel1 ? rt_bresp : '0;
  assign m1.arready = sel1 & rt_arready;
  assign m1.rvalid  = sel1 & rt_rvalid;
  assign m1.rresp   = sel1 ? rt_rresp : '0;
  assign m1.rdata   = sel1 ? rt_rdata : '0;

  logic aw_fire, w_fire, ar_fire, r_fire, b_fire, g_wr_req;

  assign aw_fire  = (state_q == ST_WR_REQ)  & g_awvalid & ~aw_done_q & s.awready;
  assign w_fire   = (state_q == ST_WR_REQ)  & g_wvalid  & ~w_done_q  & s.wready;
  assign ar_fire  = (state_q == ST_RD_ADDR) & g_arvalid & s.arready;
  assign r_fire   = (state_q == ST_RD_DATA) & s.rvalid  & g_rready;
  assign b_fire   = (state_q == ST_WR_RESP) & s.bvalid  & g_bready;
  assign g_wr_req = arb_gnt[1] ? (m1.awvalid | m1.wvalid) : (m0.awvalid | m0.wvalid);

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    gnt_d     = gnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|arb_gnt) begin
          gnt_d     = arb_gnt[1];
          state_d   = g_wr_req ? ST_WR_REQ : ST_RD_ADDR;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      ST_RD_ADDR: if (ar_fire) state_d = ST_RD_DATA;
      ST_RD_DATA: begin
        if (r_fire) begin
          state_d = ST_IDLE;
          prio_d  = ~gnt_q;
        end
      end
      ST_WR_REQ: begin
        if (aw_fire) aw_done_d = 1'b1;
        if (w_fire)  w_done_d  = 1'b1;
        if ((aw_done_q | aw_fire) & (w_done_q | w_fire)) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (b_fire) begin
          state_d = ST_IDLE;
          prio_d  = ~gnt_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      state_q   <= ST_IDLE;
      prio_q    <= MST_M0;
      gnt_q     <= MST_M0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      gnt_q     <= gnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axi_4_lite_arbiter.sv
// Directed bench for the two-master AXI4-lite arbiter with a small memory-slave
// model; read data is address XOR 0x8000_0013.
module tb_axi_4_lite_arbiter;
  import axi_4_lite_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_4_lite_arbiter_if m0_if ();
  axi_4_lite_arbiter_if m1_if ();
  axi_4_lite_arbiter_if s_if ();

  axi_4_lite_arbiter dut (
    .AXI_ACLK   (clk),
    .AXI_ARESET (rst),
    .m0         (m0_if),
    .m1         (m1_if),
    .s          (s_if)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  always @(posedge clk) cyc++;

  // Slave model
  assign s_if.arready = 1'b1;
  assign s_if.awready = 1'b1;
  assign s_if.wready  = 1'b1;

  int          rd_lat   = 0;
  logic [1:0]  resp_cfg = RESP_OKAY;
  logic        rpend, aw_got, w_got;
  int          rcnt;
  logic [31:0] raddr, cap_awaddr;
  logic [63:0] cap_wdata;
  logic [7:0]  cap_wstrb;
  int          aw_cnt;

  always @(posedge clk) begin
    if (rst) begin
      s_if.rvalid <= 1'b0; s_if.rdata <= '0; s_if.rresp <= '0;
      s_if.bvalid <= 1'b0; s_if.bresp <= '0;
      rpend <= 1'b0; rcnt <= 0; aw_got <= 1'b0; w_got <= 1'b0; raddr <= '0;
    end else begin
      if (s_if.arvalid && s_if.arready) begin
        rpend <= 1'b1; rcnt <= rd_lat; raddr <= s_if.araddr;
      end else if (rpend) begin
        if (rcnt == 0) begin
          s_if.rvalid <= 1'b1;
          s_if.rdata  <= {32'h0, raddr ^ 32'h8000_0013};
          s_if.rresp  <= resp_cfg;
          rpend       <= 1'b0;
        end else rcnt <= rcnt - 1;
      end
      if (s_if.rvalid && s_if.rready) s_if.rvalid <= 1'b0;
      if (s_if.awvalid && s_if.awready) begin
        cap_awaddr <= s_if.awaddr; aw_cnt <= aw_cnt + 1;
      end
      if (s_if.wvalid && s_if.wready) begin
        cap_wdata <= s_if.wdata; cap_wstrb <= s_if.wstrb;
      end
      if ((aw_got || (s_if.awvalid && s_if.awready)) &&
          (w_got || (s_if.wvalid && s_if.wready)) && !s_if.bvalid) begin
        s_if.bvalid <= 1'b1; s_if.bresp <= resp_cfg;
        aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        aw_got <= aw_got || (s_if.awvalid && s_if.awready);
        w_got  <= w_got  || (s_if.wvalid && s_if.wready);
      end
      if (s_if.bvalid && s_if.bready) s_if.bvalid <= 1'b0;
    end
  end

  // Handshake log: 0/1 = read by M0/M1, 2/3 = write address by M0/M1
  int order_q[$];
  int t_m0_rhs = -1, t_m1_ar = -1;
  int active_m = -1;
  int stray    = 0;

  function automatic bit m_out_nz(input int m);
    if (m == 0)
      return |{m0_if.arready, m0_if.awready, m0_if.wready, m0_if.rvalid,
               m0_if.bvalid, m0_if.rdata, m0_if.rresp, m0_if.bresp};
    return |{m1_if.arready, m1_if.awready, m1_if.wready, m1_if.rvalid,
             m1_if.bvalid, m1_if.rdata, m1_if.rresp, m1_if.bresp};
  endfunction

  function automatic bit outs_nz();
    return m_out_nz(0) | m_out_nz(1) |
           (|{s_if.arvalid, s_if.awvalid, s_if.wvalid, s_if.rready, s_if.bready,
              s_if.araddr, s_if.awaddr, s_if.wdata, s_if.wstrb, s_if.arprot, s_if.awprot});
  endfunction

  always @(negedge clk) begin
    if (m0_if.arvalid && m0_if.arready) order_q.push_back(0);
    if (m1_if.arvalid && m1_if.arready) begin
      order_q.push_back(1);
      if (t_m1_ar < 0) t_m1_ar = cyc;
    end
    if (m0_if.awvalid && m0_if.awready) order_q.push_back(2);
    if (m1_if.awvalid && m1_if.awready) order_q.push_back(3);
    if (m0_if.rvalid && m0_if.rready) t_m0_rhs = cyc;
    if (active_m >= 0 && m_out_nz(1 - active_m)) stray++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    compared++;
    mismatched++;
    $display("FAIL timeout %s: got no handshake, expected one within 200 cycles", name);
  endtask

  // Master drivers
  task automatic drv_ar(input int m, input logic v, input logic [31:0] a);
    if (m == 0) begin m0_if.arvalid = v; m0_if.araddr = a; end
    else        begin m1_if.arvalid = v; m1_if.araddr = a; end
  endtask
  task automatic drv_aw(input int m, input logic v, input logic [31:0] a);
    if (m == 0) begin m0_if.awvalid = v; m0_if.awaddr = a; end
    else        begin m1_if.awvalid = v; m1_if.awaddr = a; end
  endtask
  task automatic drv_w(input int m, input logic v, input logic [63:0] d, input logic [7:0] st);
    if (m == 0) begin m0_if.wvalid = v; m0_if.wdata = d; m0_if.wstrb = st; end
    else        begin m1_if.wvalid = v; m1_if.wdata = d; m1_if.wstrb = st; end
  endtask
  task automatic drv_rb(input int m, input logic rr, input logic br);
    if (m == 0) begin m0_if.rready = rr; m0_if.bready = br; end
    else        begin m1_if.rready = rr; m1_if.bready = br; end
  endtask

  task automatic wait_flag(input int m, input int which, input string name, output bit ok);
    int n = 0;
    bit f;
    ok = 1'b1;
    forever begin
      @(negedge clk);
      case (which)
        0: f = (m == 0) ? m0_if.arready : m1_if.arready;
        1: f = (m == 0) ? m0_if.rvalid  : m1_if.rvalid;
        2: f = (m == 0) ? m0_if.awready : m1_if.awready;
        3: f = (m == 0) ? m0_if.wready  : m1_if.wready;
        default: f = (m == 0) ? m0_if.bvalid : m1_if.bvalid;
      endcase
      if (f) return;
      n++;
      if (n > 200) begin timeout(name); ok = 1'b0; return; end
    end
  endtask

  task automatic do_read(input int m, input logic [31:0] a,
                         output logic [63:0] d, output logic [1:0] r);
    bit ok;
    d = '0; r = '0;
    drv_ar(m, 1'b1, a);
    wait_flag(m, 0, "rd_addr", ok);
    if (ok) @(posedge clk);
    #1 drv_ar(m, 1'b0, '0);
    if (!ok) return;
    drv_rb(m, 1'b1, 1'b0);
    wait_flag(m, 1, "rd_data", ok);
    if (ok) begin
      d = (m == 0) ? m0_if.rdata : m1_if.rdata;
      r = (m == 0) ? m0_if.rresp : m1_if.rresp;
      @(posedge clk);
    end
    #1 drv_rb(m, 1'b0, 1'b0);
  endtask

  task automatic do_write(input int m, input logic [31:0] a, input logic [63:0] d,
                          input logic [7:0] st, output logic [1:0] r);
    bit ok_aw, ok_w, ok_b;
    r = '0;
    drv_aw(m, 1'b1, a);
    drv_w(m, 1'b1, d, st);
    fork
      begin
        wait_flag(m, 2, "wr_addr", ok_aw);
        if (ok_aw) @(posedge clk);
        #1 drv_aw(m, 1'b0, '0);
      end
      begin
        wait_flag(m, 3, "wr_data", ok_w);
        if (ok_w) @(posedge clk);
        #1 drv_w(m, 1'b0, '0, '0);
      end
    join
    if (!(ok_aw && ok_w)) return;
    drv_rb(m, 1'b0, 1'b1);
    wait_flag(m, 4, "wr_resp", ok_b);
    if (ok_b) begin
      r = (m == 0) ? m0_if.bresp : m1_if.bresp;
      @(posedge clk);
    end
    #1 drv_rb(m, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    int          m;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic [1:0]  resp;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t        tbl[6];
  logic [63:0] rd;
  logic [1:0]  rr;

  initial begin
    tbl[0] = '{0, 0, 32'h8000_0000, 64'h0, 8'h00, RESP_OKAY,   64'h0000_0000_0000_0013};
    tbl[1] = '{0, 1, 32'h8000_0100, 64'h0, 8'h00, RESP_EXOKAY, 64'h0000_0000_0000_0113};
    tbl[2] = '{1, 1, 32'h0000_0040, 64'h1122_3344_5566_7788, 8'hFF, RESP_OKAY, 64'h0};
    tbl[3] = '{0, 0, 32'h1234_5678, 64'h0, 8'h00, RESP_SLVERR, 64'h0000_0000_9234_566B};
    tbl[4] = '{1, 0, 32'hA000_0008, 64'hDEAD_BEEF_0BAD_F00D, 8'h0F, RESP_DECERR, 64'h0};
    tbl[5] = '{0, 1, 32'hFFFF_FFFF, 64'h0, 8'h00, RESP_OKAY,   64'h0000_0000_7FFF_FFEC};

    m0_if.awaddr = '0; m0_if.awprot = '0; m0_if.awvalid = 0; m0_if.wdata = '0;
    m0_if.wstrb = '0; m0_if.wvalid = 0; m0_if.bready = 0; m0_if.araddr = '0;
    m0_if.arprot = '0; m0_if.arvalid = 0; m0_if.rready = 0;
    m1_if.awaddr = '0; m1_if.awprot = '0; m1_if.awvalid = 0; m1_if.wdata = '0;
    m1_if.wstrb = '0; m1_if.wvalid = 0; m1_if.bready = 0; m1_if.araddr = '0;
    m1_if.arprot = '0; m1_if.arvalid = 0; m1_if.rready = 0;
    cap_awaddr = '0; cap_wdata = '0; cap_wstrb = '0; aw_cnt = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_zero", 64'(outs_nz()), 64'd0);
    chk("reset_state_idle", 64'(dut.state_q), 64'(ST_IDLE));
    rst = 1'b0;

    // Lone read by M0 with per-cycle latency checks
    @(posedge clk); #1;
    m0_if.arprot = 3'b101;
    drv_ar(0, 1'b1, 32'h8000_0000);
    @(negedge clk);
    chk("lone_s_arvalid_idle", 64'(s_if.arvalid), 64'd0);
    @(negedge clk);
    chk("lone_s_arvalid", 64'(s_if.arvalid), 64'd1);
    chk("lone_s_araddr", 64'(s_if.araddr), 64'h8000_0000);
    chk("lone_s_arprot", 64'(s_if.arprot), 64'd5);
    chk("lone_m0_arready", 64'(m0_if.arready), 64'd1);
    chk("lone_m1_zero_a", 64'(m_out_nz(1)), 64'd0);
    @(posedge clk); #1;
    drv_ar(0, 1'b0, '0); m0_if.arprot = '0; drv_rb(0, 1'b1, 1'b0);
    @(negedge clk);
    chk("lone_m0_rvalid_wait", 64'(m0_if.rvalid), 64'd0);
    @(negedge clk);
    chk("lone_m0_rvalid", 64'(m0_if.rvalid), 64'd1);
    chk("lone_m0_rdata", m0_if.rdata, 64'h13);
    chk("lone_m0_rresp", 64'(m0_if.rresp), 64'(RESP_OKAY));
    chk("lone_m1_zero_r", 64'(m_out_nz(1)), 64'd0);
    @(posedge clk); #1;
    drv_rb(0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lone_back_idle", 64'(m0_if.rvalid | s_if.rready), 64'd0);

    // Table of single-master transactions
    for (int i = 0; i < 6; i++) begin
      resp_cfg = tbl[i].resp;
      active_m = tbl[i].m;
      stray = 0;
      if (tbl[i].wr) begin
        do_write(tbl[i].m, tbl[i].addr, tbl[i].wdata, tbl[i].strb, rr);
        chk($sformatf("tbl%0d_bresp", i), 64'(rr), 64'(tbl[i].resp));
        chk($sformatf("tbl%0d_awaddr", i), 64'(cap_awaddr), 64'(tbl[i].addr));
        chk($sformatf("tbl%0d_wdata", i), cap_wdata, tbl[i].wdata);
        chk($sformatf("tbl%0d_wstrb", i), 64'(cap_wstrb), 64'(tbl[i].strb));
      end else begin
        do_read(tbl[i].m, tbl[i].addr, rd, rr);
        chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
        chk($sformatf("tbl%0d_rresp", i), 64'(rr), 64'(tbl[i].resp));
      end
      active_m = -1;
      chk($sformatf("tbl%0d_other_master_quiet", i), 64'(stray), 64'd0);
    end
    resp_cfg = RESP_OKAY;

    // Simultaneous reads right after reset: M0 first, one IDLE cycle gap
    apply_reset();
    order_q.delete(); t_m0_rhs = -1; t_m1_ar = -1;
    fork
      begin logic [63:0] d0; logic [1:0] r0; do_read(0, 32'h8000_0000, d0, r0); end
      begin logic [63:0] d1; logic [1:0] r1; do_read(1, 32'h8000_0004, d1, r1);
            chk("simul_m1_rdata", d1, 64'h17); end
    join
    chk("simul_count", 64'(order_q.size()), 64'd2);
    if (order_q.size() == 2) begin
      chk("simul_first", 64'(order_q[0]), 64'd0);
      chk("simul_second", 64'(order_q[1]), 64'd1);
    end
    chk("simul_idle_gap", 64'(t_m1_ar - t_m0_rhs), 64'd2);

    // Split write by M1: AW at cycle 2, W at cycle 5
    aw_cnt = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    drv_aw(1, 1'b1, 32'h0000_1000);
    @(negedge clk);
    chk("split_s_awvalid_idle", 64'(s_if.awvalid), 64'd0);
    @(negedge clk);
    chk("split_s_awvalid", 64'(s_if.awvalid), 64'd1);
    chk("split_s_awaddr", 64'(s_if.awaddr), 64'h1000);
    chk("split_s_wvalid_early", 64'(s_if.wvalid), 64'd0);
    @(negedge clk);
    chk("split_s_awvalid_done", 64'(s_if.awvalid), 64'd0);
    chk("split_m1_awready_done", 64'(m1_if.awready), 64'd0);
    chk("split_b_not_routed", 64'(m1_if.bvalid | s_if.bready), 64'd0);
    @(posedge clk); #1;
    drv_aw(1, 1'b0, '0);
    drv_w(1, 1'b1, 64'h1122_3344_5566_7788, 8'hFF);
    @(negedge clk);
    chk("split_s_wvalid", 64'(s_if.wvalid), 64'd1);
    chk("split_s_wdata", s_if.wdata, 64'h1122_3344_5566_7788);
    chk("split_s_wstrb", 64'(s_if.wstrb), 64'hFF);
    chk("split_m1_wready", 64'(m1_if.wready), 64'd1);
    chk("split_b_before_w", 64'(m1_if.bvalid | s_if.bready), 64'd0);
    @(posedge clk); #1;
    drv_w(1, 1'b0, '0, '0);
    drv_rb(1, 1'b0, 1'b1);
    @(negedge clk);
    chk("split_m1_bvalid", 64'(m1_if.bvalid), 64'd1);
    chk("split_m1_bresp", 64'(m1_if.bresp), 64'(RESP_OKAY));
    chk("split_m0_quiet", 64'(m_out_nz(0)), 64'd0);
    @(posedge clk); #1;
    drv_rb(1, 1'b0, 1'b0);
    @(negedge clk);
    chk("split_m1_bvalid_end", 64'(m1_if.bvalid), 64'd0);
    chk("split_single_aw", 64'(aw_cnt), 64'd1);

    // Read/write conflict inside M1: write first
    order_q.delete();
    fork
      begin logic [1:0] wr_r; do_write(1, 32'h0000_0080, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, wr_r); end
      begin logic [63:0] d2; logic [1:0] r2; do_read(1, 32'h8000_0080, d2, r2);
            chk("conflict_rdata", d2, 64'h93); end
    join
    chk("conflict_count", 64'(order_q.size()), 64'd2);
    if (order_q.size() == 2) begin
      chk("conflict_write_first", 64'(order_q[0]), 64'd3);
      chk("conflict_read_second", 64'(order_q[1]), 64'd1);
    end

    // Fairness: both masters request continuously for 8 transactions
    apply_reset();
    order_q.delete();
    fork
      for (int k = 0; k < 4; k++) begin
        logic [63:0] d3; logic [1:0] r3; do_read(0, 32'h8000_0000 + 32'(k), d3, r3);
      end
      for (int k = 0; k < 4; k++) begin
        logic [63:0] d4; logic [1:0] r4; do_read(1, 32'h8000_0010 + 32'(k), d4, r4);
      end
    join
    chk("fair_count", 64'(order_q.size()), 64'd8);
    for (int k = 0; k < 8 && k < order_q.size(); k++)
      chk($sformatf("fair_grant%0d", k), 64'(order_q[k]), 64'(k % 2));

    // Mid-operation reset during RD_DATA, prio left at M1 beforehand
    do_read(0, 32'h8000_0000, rd, rr);
    rd_lat = 20;
    @(posedge clk); #1;
    drv_ar(0, 1'b1, 32'h8000_0020);
    @(negedge clk);
    @(negedge clk);
    chk("mrst_ar_granted", 64'(m0_if.arready), 64'd1);
    @(posedge clk); #1;
    drv_ar(0, 1'b0, '0); drv_rb(0, 1'b1, 1'b0);
    @(negedge clk);
    chk("mrst_in_rd_data", 64'({s_if.rready, m0_if.rvalid}), 64'b10);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_outputs_zero", 64'(outs_nz()), 64'd0);
    chk("mrst_state_idle", 64'(dut.state_q), 64'(ST_IDLE));
    rst = 1'b0;
    drv_rb(0, 1'b0, 1'b0);
    rd_lat = 0;
    order_q.delete();
    fork
      begin logic [63:0] d5; logic [1:0] r5; do_read(0, 32'h8000_0000, d5, r5); end
      begin logic [63:0] d6; logic [1:0] r6; do_read(1, 32'h8000_0000, d6, r6); end
    join
    chk("mrst_count", 64'(order_q.size()), 64'd2);
    if (order_q.size() > 0) chk("mrst_next_grant_m0", 64'(order_q[0]), 64'd0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected completion before 200000");
    $fatal(1);
  end

endmodule
